tsi_serial_responder: RTL and testbench
=======================================

TSI_SERIAL_RESPONDER -- requirements
Module: tsi_serial_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, SHALL set the memory address width; legal range is 32..64.
REQ-002 Parameter SERIAL_WIDTH, default 32, SHALL set the serial word width; only 32 is legal.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 serial_in_valid  input  1  host word available.
REQ-006 serial_in_ready  output  1  responder accepts serial_in_bits this cycle.
REQ-007 serial_in_bits  input  SERIAL_WIDTH  host-to-chip word.
REQ-008 serial_out_valid  output  1  read-data word available to host.
REQ-009 serial_out_ready  input  1  host accepts serial_out_bits.
REQ-010 serial_out_bits  output  SERIAL_WIDTH  chip-to-host read data.
REQ-011 mem_req_valid  output  1  memory request valid.
REQ-012 mem_req_ready  input  1  memory accepts request.
REQ-013 mem_req_write  output  1  1 = write, 0 = read.
REQ-014 mem_req_addr  output  ADDR_WIDTH  byte address, 4-byte aligned.
REQ-015 mem_req_data  output  32  write data.
REQ-016 mem_resp_valid  input  1  one-cycle pulse; read data or write ack; always accepted.
REQ-017 mem_resp_data  input  32  read data; ignored for writes.
REQ-018 busy  output  1  high in every state except CMD.
REQ-019 bad_cmd  output  1  one-cycle pulse on an unknown command.

Function
REQ-020 A transfer SHALL be the word sequence CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN+1 data words for writes only; LEN is the word count minus one.
REQ-021 CMD value 0 SHALL be read, 1 SHALL be write, any other value unknown.
REQ-022 A word SHALL transfer only on a cycle with valid and ready both high; nothing else consumes or produces a word.
REQ-023 FSM states SHALL be CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, WDATA, WREQ, WACK, RREQ, RWAIT, RDATA.
REQ-024 serial_in_ready SHALL be high exactly in CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI and WDATA.
REQ-025 Header states SHALL advance by one state per accepted word.
REQ-026 ADDR_HI bits above ADDR_WIDTH SHALL be discarded.
REQ-027 After LEN_HI, the FSM SHALL go to WDATA for a write, RREQ for a read, or CMD for an unknown command.
REQ-028 For an unknown command, bad_cmd SHALL pulse in the cycle after the LEN_HI accept, with no memory traffic.
REQ-029 WDATA SHALL latch the accepted word into mem_req_data and go to WREQ.
REQ-030 WREQ SHALL hold mem_req_valid=1 with mem_req_write=1 and stable address and data until mem_req_ready, then go to WACK.
REQ-031 WACK SHALL wait for mem_resp_valid, then go to CMD if the remaining count is 0, else to WDATA.
REQ-032 RREQ SHALL hold mem_req_valid=1 with mem_req_write=0 until mem_req_ready, then go to RWAIT.
REQ-033 RWAIT SHALL latch mem_resp_data on mem_resp_valid and go to RDATA.
REQ-034 RDATA SHALL hold serial_out_valid=1 and stable bits until serial_out_ready, then go to CMD if the remaining count is 0, else to RREQ.
REQ-035 The memory interface SHALL have at most one request outstanding; mem_req_valid SHALL be low outside WREQ and RREQ.
REQ-036 serial_out_valid SHALL be low outside RDATA.
REQ-037 After each memory response, the address SHALL increment by 4 modulo 2^ADDR_WIDTH (wrap, no error).
REQ-038 After each data word, the 64-bit remaining count SHALL decrement.
REQ-039 LEN = 2^64-1 SHALL be legal and SHALL not overflow the counter.
REQ-040 A mem_resp_valid outside WACK and RWAIT SHALL be ignored.
REQ-041 Minimum per-word latency SHALL be 3 cycles for writes (WDATA accept to ack with zero-wait memory) and 3 cycles for reads (request to serial_out_valid).
REQ-042 The first mem_req_valid SHALL assert one cycle after the LEN_HI accept for a read, or after the first data accept for a write.

Reset
REQ-043 While reset is asserted, the FSM SHALL be in CMD and address, count and data registers SHALL be 0.
REQ-044 While reset is asserted, serial_in_ready, serial_out_valid, mem_req_valid, busy and bad_cmd SHALL be 0.
REQ-045 Reset mid-transfer SHALL abandon the transfer immediately, with no completion of any in-flight memory or serial handshake.
REQ-046 After reset deassertion, serial_in_ready SHALL go to 1 on the first clock edge.

Verification
REQ-047 Write: words 1, 0x80000000, 0, 1, 0, 0xAAAA5555, 0x12345678 -> memory writes 0xAAAA5555@0x80000000 and 0x12345678@0x80000004; busy low afterwards.
REQ-048 Read: words 0, 0x80000000, 0, 2, 0, memory returning 0xA, 0xB, 0xC -> serial_out carries 0xA, 0xB, 0xC; reads issued to 0x...00/04/08.
REQ-049 Backpressure: random stalls on mem_req_ready and serial_out_ready (50%) -> no dropped or duplicated words; outputs stable while stalled.
REQ-050 Unknown command: command 7 followed by four header words -> one bad_cmd pulse, no mem_req_valid, next command processed normally.
REQ-051 Address wrap: ADDR_WIDTH=32, address 0xFFFFFFFC, LEN=1 write -> addresses 0xFFFFFFFC then 0x00000000.
REQ-052 Reset in RWAIT -> all outputs 0 asynchronously; a later read completes correctly.

Source files
------------

// File: rtl/tsi_serial_responder.sv
// Serial-word responder: decodes CMD/ADDR/LEN header words from the host and drives a
// single-outstanding 32-bit memory port. ADDR_WIDTH 32..64; SERIAL_WIDTH must be 32.
module tsi_serial_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int SERIAL_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    serial_in_valid,
    output logic                    serial_in_ready,
    input  logic [SERIAL_WIDTH-1:0] serial_in_bits,
    output logic                    serial_out_valid,
    input  logic                    serial_out_ready,
    output logic [SERIAL_WIDTH-1:0] serial_out_bits,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [31:0]             mem_req_data,
    input  logic                    mem_resp_valid,
    input  logic [31:0]             mem_resp_data,
    output logic                    busy,
    output logic                    bad_cmd
);
    typedef enum logic [3:0] {
        S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI,
        S_WDATA, S_WREQ, S_WACK, S_RREQ, S_RWAIT, S_RDATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_req_valid;
    logic                  r_req_write;
    logic                  r_busy;
    logic                  r_bad_cmd;
    logic                  r_is_wr;
    logic                  r_is_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [63:0]           r_cnt;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;

    logic w_in_fire;
    logic w_out_fire;
    logic w_req_fire;
    logic w_last;
    logic w_cmd_wr;
    logic w_cmd_rd;

    // Handshakes use the registered flags, which always mirror the current state.
    assign w_in_fire  = serial_in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & serial_out_ready;
    assign w_req_fire = r_req_valid & mem_req_ready;
    assign w_last     = (r_cnt == 64'd0);
    assign w_cmd_wr   = (serial_in_bits == SERIAL_WIDTH'(1));
    assign w_cmd_rd   = (serial_in_bits == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CMD:     if (w_in_fire) w_state_nxt = S_ADDR_LO;
            S_ADDR_LO: if (w_in_fire) w_state_nxt = S_ADDR_HI;
            S_ADDR_HI: if (w_in_fire) w_state_nxt = S_LEN_LO;
            S_LEN_LO:  if (w_in_fire) w_state_nxt = S_LEN_HI;
            S_LEN_HI:  if (w_in_fire) w_state_nxt = r_is_wr ? S_WDATA : (r_is_rd ? S_RREQ : S_CMD);
            S_WDATA:   if (w_in_fire) w_state_nxt = S_WREQ;
            S_WREQ:    if (w_req_fire) w_state_nxt = S_WACK;
            S_WACK:    if (mem_resp_valid) w_state_nxt = w_last ? S_CMD : S_WDATA;
            S_RREQ:    if (w_req_fire) w_state_nxt = S_RWAIT;
            S_RWAIT:   if (mem_resp_valid) w_state_nxt = S_RDATA;
            S_RDATA:   if (w_out_fire) w_state_nxt = w_last ? S_CMD : S_RREQ;
            default:   w_state_nxt = S_CMD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_CMD;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_busy      <= 1'b0;
            r_bad_cmd   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_is_rd     <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Output flags are decoded from the next state so they land with it.
            r_in_ready  <= w_state_nxt inside {S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_WDATA};
            r_out_valid <= (w_state_nxt == S_RDATA);
            r_req_valid <= w_state_nxt inside {S_WREQ, S_RREQ};
            r_req_write <= (w_state_nxt == S_WREQ);
            r_busy      <= (w_state_nxt != S_CMD);
            r_bad_cmd   <= (r_state == S_LEN_HI) && w_in_fire && !r_is_wr && !r_is_rd;
            case (r_state)
                S_CMD: if (w_in_fire) begin
                    r_is_wr <= w_cmd_wr;
                    r_is_rd <= w_cmd_rd;
                end
                S_ADDR_LO: if (w_in_fire) r_addr[31:0] <= serial_in_bits;
                S_ADDR_HI: if (w_in_fire) r_addr <= ADDR_WIDTH'({serial_in_bits, r_addr[31:0]});
                S_LEN_LO:  if (w_in_fire) r_cnt[31:0] <= serial_in_bits;
                S_LEN_HI:  if (w_in_fire) r_cnt[63:32] <= serial_in_bits;
                S_WDATA:   if (w_in_fire) r_wdata <= serial_in_bits;
                S_WACK: if (mem_resp_valid) begin
                    r_addr <= r_addr + ADDR_WIDTH'(4);
                    if (!w_last) r_cnt <= r_cnt - 64'd1;
                end
                S_RWAIT: if (mem_resp_valid) begin
                    r_rdata <= mem_resp_data;
                    r_addr  <= r_addr + ADDR_WIDTH'(4);
                end
                // The count is held at zero on the last word, so LEN of all-ones never wraps.
                S_RDATA: if (w_out_fire && !w_last) r_cnt <= r_cnt - 64'd1;
                default: ;
            endcase
        end
    end

    assign serial_in_ready  = r_in_ready;
    assign serial_out_valid = r_out_valid;
    assign serial_out_bits  = r_rdata;
    assign mem_req_valid    = r_req_valid;
    assign mem_req_write    = r_req_write;
    assign mem_req_addr     = r_addr;
    assign mem_req_data     = r_wdata;
    assign busy             = r_busy;
    assign bad_cmd          = r_bad_cmd;
endmodule

// File: tb/tb_tsi_serial_responder.sv
// Bench for tsi_serial_responder: per-cycle vector table plus hand sequences for reset,
// huge LEN, and a randomized backpressure run against a small memory model.
module tb_tsi_serial_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        siv = 1'b0;
    logic [31:0] sib = 32'd0;
    logic        sor = 1'b0;
    logic        qr = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rd = 32'd0;

    logic        sir, sov, qv, qw, busy, bad;
    logic [31:0] sob, qd;
    logic [63:0] qa;
    logic        sir32, sov32, qv32, qw32, busy32, bad32;
    logic [31:0] sob32, qd32, qa32;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    tsi_serial_responder #(.ADDR_WIDTH(64), .SERIAL_WIDTH(32)) u_dut (
        .clock(clock), .reset(reset),
        .serial_in_valid(siv), .serial_in_ready(sir), .serial_in_bits(sib),
        .serial_out_valid(sov), .serial_out_ready(sor), .serial_out_bits(sob),
        .mem_req_valid(qv), .mem_req_ready(qr), .mem_req_write(qw),
        .mem_req_addr(qa), .mem_req_data(qd),
        .mem_resp_valid(rv), .mem_resp_data(rd),
        .busy(busy), .bad_cmd(bad)
    );

    tsi_serial_responder #(.ADDR_WIDTH(32), .SERIAL_WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset),
        .serial_in_valid(siv), .serial_in_ready(sir32), .serial_in_bits(sib),
        .serial_out_valid(sov32), .serial_out_ready(sor), .serial_out_bits(sob32),
        .mem_req_valid(qv32), .mem_req_ready(qr), .mem_req_write(qw32),
        .mem_req_addr(qa32), .mem_req_data(qd32),
        .mem_resp_valid(rv), .mem_resp_data(rd),
        .busy(busy32), .bad_cmd(bad32)
    );

    typedef struct {
        bit        iv;
        bit [31:0] ib;
        bit        ordy;
        bit        qrdy;
        bit        rv;
        bit [31:0] rd;
        bit        x_ir;
        bit        x_ov;
        bit [31:0] x_ob;
        bit        x_qv;
        bit        x_qw;
        bit [63:0] x_qa;
        bit [31:0] x_qd;
        bit        x_busy;
        bit        x_bad;
    } vec_t;

    vec_t vq[$];

    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    logic [63:0] addr_q[$];
    logic [31:0] mem_m [logic [63:0]];

    function automatic vec_t mk(bit iv, bit [31:0] ib, bit ordy, bit qrdy, bit rvi, bit [31:0] rdi,
                                bit ir, bit ov, bit [31:0] ob, bit q_v, bit q_w, bit [63:0] q_a,
                                bit [31:0] q_d, bit bz, bit bd);
        vec_t v;
        v.iv = iv; v.ib = ib; v.ordy = ordy; v.qrdy = qrdy; v.rv = rvi; v.rd = rdi;
        v.x_ir = ir; v.x_ov = ov; v.x_ob = ob; v.x_qv = q_v; v.x_qw = q_w; v.x_qa = q_a;
        v.x_qd = q_d; v.x_busy = bz; v.x_bad = bd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int k;
        siv = 1'b1;
        sib = w;
        k = 0;
        while (!sir && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("send_ready", 64'(sir), 64'd1);
        @(negedge clock);
        siv = 1'b0;
    endtask

    // Sends one data word of a write and completes it with a zero-wait memory.
    task automatic wword(input logic [31:0] d, input logic [63:0] a);
        send(d);
        chk("wword_qv", 64'(qv), 64'd1);
        chk("wword_qa", qa, a);
        chk("wword_qd", 64'(qd), 64'(d));
        qr = 1'b1;
        @(negedge clock);
        qr = 1'b0;
        rv = 1'b1;
        @(negedge clock);
        rv = 1'b0;
    endtask

    task automatic bp_run();
        int          cyc_n;
        int          pend;
        int          dly;
        logic [31:0] pdata;
        logic        p_qv, p_qw, p_ov;
        logic [63:0] p_qa;
        logic [31:0] p_qd, p_ob;
        cyc_n = 0; pend = 0; dly = 0; pdata = 32'd0;
        p_qv = 1'b0; p_qw = 1'b0; p_ov = 1'b0; p_qa = 64'd0; p_qd = 32'd0; p_ob = 32'd0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || busy || pend != 0) && cyc_n < 3000) begin
            if (p_qv) begin
                chk("bp_qv_hold", 64'(qv), 64'd1);
                chk("bp_qa_hold", qa, p_qa);
                chk("bp_qd_hold", 64'(qd), 64'(p_qd));
                chk("bp_qw_hold", 64'(qw), 64'(p_qw));
            end
            if (p_ov) begin
                chk("bp_ov_hold", 64'(sov), 64'd1);
                chk("bp_ob_hold", 64'(sob), 64'(p_ob));
            end
            rv = 1'b0;
            if (pend != 0) begin
                if (dly == 0) begin
                    rv = 1'b1;
                    rd = pdata;
                    pend = 0;
                end else dly--;
            end
            siv = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
            sib = (in_q.size() > 0) ? in_q[0] : 32'd0;
            if (siv && sir) void'(in_q.pop_front());
            sor = 1'($urandom_range(0, 1));
            qr  = 1'($urandom_range(0, 1));
            if (sov && sor) begin
                if (exp_q.size() == 0) chk("bp_extra_out", 64'd1, 64'd0);
                else chk("bp_rdata", 64'(sob), 64'(exp_q.pop_front()));
            end
            if (qv && qr) begin
                if (addr_q.size() == 0) chk("bp_extra_req", 64'd1, 64'd0);
                else chk("bp_addr", qa, addr_q.pop_front());
                if (qw) mem_m[qa] = qd;
                else pdata = mem_m.exists(qa) ? mem_m[qa] : 32'hDEADBEEF;
                pend = 1;
                dly = $urandom_range(0, 2);
            end
            p_qv = qv && !qr; p_qa = qa; p_qd = qd; p_qw = qw;
            p_ov = sov && !sor; p_ob = sob;
            @(negedge clock);
            cyc_n++;
        end
        siv = 1'b0; sor = 1'b0; qr = 1'b0; rv = 1'b0;
        chk("bp_timeout", 64'(cyc_n >= 3000), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Write REQ: 2 words at 0x80000000, a host stall, a memory stall, a late ack.
        vq.push_back(mk(1, 1,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        vq.push_back(mk(1, 'h80000000,   0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 1,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 'hAAAA5555,   0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 0,0,0,1,1,64'h80000000,'hAAAA5555, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,1,64'h80000000,'hAAAA5555, 1,0));
        vq.push_back(mk(1, 'h12345678,   0,0,0,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 'h12345678,   0,0,1,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 'h12345678,   0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,1,64'h80000004,'h12345678, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        // Read of 3 words at 0x80000000 with stray responses in RREQ and RDATA.
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        vq.push_back(mk(1, 'h80000000,   0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 2,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,1,'hDEAD, 0,0,0,1,0,64'h80000000,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,'hA, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,'hBAD, 0,1,'hA,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            1,0,0,0, 0,1,'hA,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,0,64'h80000004,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,'hB, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            1,0,0,0, 0,1,'hB,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 0,0,0,1,0,64'h80000008,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,0,64'h80000008,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,'hC, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            1,0,0,0, 0,1,'hC,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        // Unknown command 7: one bad_cmd pulse, no memory traffic.
        vq.push_back(mk(1, 7,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        vq.push_back(mk(1, 'h100,        0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        // Write of 2 words at hi=1, lo=0xFFFFFFFC: 32-bit instance wraps to 0.
        vq.push_back(mk(1, 1,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));
        vq.push_back(mk(1, 'hFFFFFFFC,   0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 1,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 1,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 0,            0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 'h11,         0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,1,64'h1_FFFFFFFC,'h11, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(1, 'h22,         0,0,0,0, 1,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,1,0,0, 0,0,0,1,1,64'h2_00000000,'h22, 1,0));
        vq.push_back(mk(0, 0,            0,0,1,0, 0,0,0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,            0,0,0,0, 1,0,0,0,0,0,0, 0,0));

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(sir), 64'd0);
        chk("rst_out_valid", 64'(sov), 64'd0);
        chk("rst_req_valid", 64'(qv), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bad_cmd", 64'(bad), 64'd0);
        chk("rst_addr", qa, 64'd0);
        chk("rst_wdata", 64'(qd), 64'd0);
        chk("rst_rdata", 64'(sob), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vq.size(); i++) begin
            siv = vq[i].iv; sib = vq[i].ib; sor = vq[i].ordy;
            qr = vq[i].qrdy; rv = vq[i].rv; rd = vq[i].rd;
            chk($sformatf("v%0d.in_ready", i), 64'(sir), 64'(vq[i].x_ir));
            chk($sformatf("v%0d.out_valid", i), 64'(sov), 64'(vq[i].x_ov));
            chk($sformatf("v%0d.req_valid", i), 64'(qv), 64'(vq[i].x_qv));
            chk($sformatf("v%0d.busy", i), 64'(busy), 64'(vq[i].x_busy));
            chk($sformatf("v%0d.bad_cmd", i), 64'(bad), 64'(vq[i].x_bad));
            if (vq[i].x_ov) chk($sformatf("v%0d.out_bits", i), 64'(sob), 64'(vq[i].x_ob));
            if (vq[i].x_qv) begin
                chk($sformatf("v%0d.req_write", i), 64'(qw), 64'(vq[i].x_qw));
                chk($sformatf("v%0d.req_addr", i), qa, vq[i].x_qa);
                if (vq[i].x_qw) chk($sformatf("v%0d.req_data", i), 64'(qd), 64'(vq[i].x_qd));
                chk($sformatf("v%0d.req_addr32", i), 64'(qa32), 64'(vq[i].x_qa[31:0]));
            end
            @(negedge clock);
        end
        siv = 1'b0; sor = 1'b0; qr = 1'b0; rv = 1'b0;

        // LEN = 2^64-1 write keeps going after several words.
        send(1); send(32'h1000); send(0); send(32'hFFFFFFFF); send(32'hFFFFFFFF);
        wword(32'h5555_0001, 64'h1000);
        wword(32'h5555_0002, 64'h1004);
        chk("biglen_in_ready", 64'(sir), 64'd1);
        chk("biglen_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset asserted while in RWAIT.
        send(0); send(32'h40); send(0); send(0); send(0);
        chk("rw_qv", 64'(qv), 64'd1);
        chk("rw_qw", 64'(qw), 64'd0);
        chk("rw_qa", qa, 64'h40);
        qr = 1'b1;
        @(negedge clock);
        qr = 1'b0;
        chk("rw_busy_wait", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rw_async_busy", 64'(busy), 64'd0);
        chk("rw_async_in_ready", 64'(sir), 64'd0);
        chk("rw_async_out_valid", 64'(sov), 64'd0);
        chk("rw_async_req_valid", 64'(qv), 64'd0);
        chk("rw_async_bad", 64'(bad), 64'd0);
        chk("rw_async_addr", qa, 64'd0);
        rv = 1'b1; rd = 32'hBADBAD00;
        @(negedge clock);
        chk("rw_hold_in_ready", 64'(sir), 64'd0);
        chk("rw_hold_out_valid", 64'(sov), 64'd0);
        reset = 1'b0; rv = 1'b0;
        @(negedge clock);
        chk("rw_post_in_ready", 64'(sir), 64'd1);
        chk("rw_post_busy", 64'(busy), 64'd0);
        send(0); send(32'h80); send(0); send(0); send(0);
        chk("rw2_qa", qa, 64'h80);
        qr = 1'b1;
        @(negedge clock);
        qr = 1'b0; rv = 1'b1; rd = 32'h5A5A5A5A;
        @(negedge clock);
        rv = 1'b0;
        chk("rw2_out_valid", 64'(sov), 64'd1);
        chk("rw2_out_bits", 64'(sob), 64'h5A5A5A5A);
        sor = 1'b1;
        @(negedge clock);
        sor = 1'b0;
        chk("rw2_done_busy", 64'(busy), 64'd0);
        chk("rw2_done_ov", 64'(sov), 64'd0);

        // Random backpressure: write 6 words then read them back.
        in_q.push_back(1); in_q.push_back(32'h2000); in_q.push_back(0);
        in_q.push_back(5); in_q.push_back(0);
        for (int i = 0; i < 6; i++) begin
            in_q.push_back(32'hC0DE0000 + 32'(i));
            addr_q.push_back(64'h2000 + 64'(4 * i));
        end
        in_q.push_back(0); in_q.push_back(32'h2000); in_q.push_back(0);
        in_q.push_back(5); in_q.push_back(0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'hC0DE0000 + 32'(i));
            addr_q.push_back(64'h2000 + 64'(4 * i));
        end
        bp_run();
        for (int i = 0; i < 6; i++) begin
            logic [63:0] a;
            a = 64'h2000 + 64'(4 * i);
            chk($sformatf("bp_mem%0d", i), mem_m.exists(a) ? 64'(mem_m[a]) : 64'hX,
                64'(32'hC0DE0000 + 32'(i)));
        end
        chk("bp_in_left", 64'(in_q.size()), 64'd0);
        chk("bp_out_left", 64'(exp_q.size()), 64'd0);
        chk("bp_req_left", 64'(addr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
